inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted requests still awaiting a response; at least 1.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning the first fetch address.
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have imem_req_o  out  1  request valid.
REQ-007 SHALL have imem_addr_o  out  XLEN  fetch address, word aligned.
REQ-008 SHALL have imem_gnt_i  in  1  request accepted this cycle.
REQ-009 SHALL have imem_rvalid_i  in  1  response valid; responses return in order.
REQ-010 SHALL have imem_rdata_i  in  XLEN  instruction word.
REQ-011 SHALL have fetch_valid_o  out  1  entry available to decode.
REQ-012 SHALL have fetch_ready_i  in  1  decode accepts the entry.
REQ-013 SHALL have fetch_pc_o  out  XLEN  and fetch_inst_o  out  XLEN, the head entry.
REQ-014 SHALL have redirect_i  in  1  branch or jump taken.
REQ-015 SHALL have redirect_pc_i  in  XLEN  target address.
REQ-016 SHALL have q_count_o  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-017 SHALL assert imem_req_o only in RUN, and only while occupancy + outstanding < DEPTH and outstanding < MAX_OUTSTANDING.
REQ-018 SHALL hold imem_addr_o stable while imem_req_o is high and imem_gnt_i is low.
REQ-019 SHALL, on a grant, advance the fetch PC by 4 (mod 2^XLEN) and increment outstanding.
REQ-020 SHALL write each non-discarded response into the queue with its request PC; the PC is tracked in a MAX_OUTSTANDING-deep PC FIFO.
REQ-021 SHALL transfer an entry when fetch_valid_o and fetch_ready_i are both high; fetch_pc_o and fetch_inst_o stay stable while valid and not ready.
REQ-022 SHALL allow enqueue and dequeue in the same cycle; when full, the credit rule guarantees no response arrives.
REQ-023 SHALL implement FSM states RUN and DRAIN.
REQ-024 SHALL handle redirect_i in the same cycle: flush the queue, load fetch PC with {redirect_pc_i[XLEN-1:2],2'b00}, and set discard count = outstanding (including a grant in that cycle).
REQ-025 SHALL go RUN->DRAIN when the discard count is nonzero, and DRAIN->RUN when it reaches 0; imem_req_o is low in DRAIN.
REQ-026 SHALL discard responses while the discard count is above 0, decrementing it; a response in the redirect cycle itself is discarded.
REQ-027 SHALL treat a redirect in DRAIN as restarting the target, with the discard count unchanged except for decrements.
REQ-028 SHALL give redirect priority over a same-cycle dequeue: the handshake completes, the entry is flushed, and the queue is empty the next cycle.
REQ-029 SHALL drive fetch_valid_o low in the cycle after a redirect.

Reset
REQ-030 SHALL, on reset, set PC=RESET_PC, state RUN, queue, outstanding and discard count to 0, fetch_valid_o=0, and q_count_o=0.
REQ-031 SHALL assert imem_req_o with imem_addr_o=RESET_PC in the first cycle after rst deasserts.
REQ-032 SHALL, on reset mid-operation, abandon all in-flight responses, and SHALL ignore any responses arriving after reset.

Configuration
REQ-033 SHALL, when FETCH_QUEUE_BYPASS_EN is defined and the queue is empty, present an accepted response on the fetch outputs in the same cycle; it bypasses the queue if fetch_ready_i is high and is enqueued otherwise.
REQ-034 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, make responses visible to decode one cycle after imem_rvalid_i, with a minimum latency of 1.

Structure
REQ-035 SHALL place the FSM state encodings and the fetch-entry field widths (PC, inst) in the shared defines.v.
REQ-036 SHALL instantiate sub-module sync_fifo (parametrised WIDTH/DEPTH, synchronous flush) twice, once for the entry queue and once for the PC FIFO.

Verification
REQ-037 SHALL verify: reset release, gnt always 1, rvalid one cycle after gnt, ready=1 -> addresses 0x0, 0x4, 0x8 in order; fetch_pc_o matches fetch_inst_o.
REQ-038 SHALL verify: ready=0, DEPTH=4 -> exactly 4 grants, then imem_req_o low and q_count_o=4; ready=1 for one cycle -> one new request.
REQ-039 SHALL verify: 2 outstanding, redirect to 0x103 -> next fetch address 0x100 only after both stale responses are dropped; no stale entries reach decode.
REQ-040 SHALL verify: redirect in the same cycle as rvalid and a dequeue -> the next cycle has q_count_o=0 and fetch_valid_o=0.
REQ-041 SHALL verify: rst asserted during DRAIN -> the next request goes to RESET_PC and late rvalid is ignored.
REQ-042 SHALL verify: with FETCH_QUEUE_BYPASS_EN and an empty queue, rvalid with rdata 0x00A00093 -> fetch_valid_o is high in the same cycle with fetch_inst_o=0x00A00093.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   fetch_state_e   : FSM encodings (RUN fetches, DRAIN drops stale responses)
//   FETCH_PC_W /
//   FETCH_INST_W    : default widths of the two fields of a queue entry
//   FETCH_PC_STEP   : byte stride between sequential fetches
//   ptr_width()     : FIFO pointer width for an arbitrary (>=1) depth
package inst_fetch_queue_pkg;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INST_W  = 32;
  localparam int FETCH_PC_STEP = 4;

  // A depth-1 FIFO still needs a one-bit pointer to stay legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush, any depth >= 1.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : synchronous clear of all entries (wins over push)
//   push/wdata: write an entry (accepted when not full, or full and popping)
//   pop       : drop the head entry (ignored when empty)
//   rdata     : head entry, valid while !empty
//   empty     : no entries held
//   count     : number of entries held
module sync_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push != do_pop) cnt <= do_push ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and count define which
  // entries are meaningful, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetcher with a decode-side queue.
// Issues word-aligned requests to instruction memory under a credit rule
// (queue occupancy + in-flight requests never exceed DEPTH), pairs each
// in-order response with its request PC and hands {pc, inst} to decode.
// A redirect flushes the queue, restarts at the target and drops the
// responses still in flight (DRAIN state) before fetching again.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o  : fetch request and its address
//   imem_gnt_i               : request accepted this cycle
//   imem_rvalid_i/rdata_i    : in-order response
//   fetch_valid_o/ready_i    : decode handshake
//   fetch_pc_o, fetch_inst_o : head entry
//   redirect_i/redirect_pc_i : taken branch/jump and its target
//   q_count_o                : queue occupancy
//
// Build option FETCH_QUEUE_BYPASS_EN: an accepted response arriving while
// the queue is empty is shown to decode in the same cycle; it skips the
// queue if decode takes it, otherwise it is enqueued. Without the macro a
// response reaches decode one cycle after imem_rvalid_i.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              XLEN            = FETCH_PC_W,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [XLEN-1:0]          imem_rdata_i,
  output logic                     fetch_valid_o,
  input  logic                     fetch_ready_i,
  output logic [XLEN-1:0]          fetch_pc_o,
  output logic [XLEN-1:0]          fetch_inst_o,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH):0]   q_count_o
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic [OCNT_W-1:0] outstanding;
  logic [OCNT_W-1:0] discard_cnt;
  logic [OCNT_W-1:0] discard_next;

  logic              gnt_fire;
  logic              rsp_fire;
  logic              rsp_drop;
  logic              rsp_keep;
  logic [XLEN-1:0]   rsp_pc;
  logic              pc_empty;

  logic              q_push;
  logic              q_pop;
  logic              q_empty;
  logic [2*XLEN-1:0] q_rdata;
  logic [QCNT_W-1:0] q_count;

  // Targets are forced to a word boundary; the low bits are never used.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // A response with no recorded request (e.g. one issued before a reset)
  // has nothing to pair with and is ignored.
  assign gnt_fire = imem_req_o && imem_gnt_i;
  assign rsp_fire = imem_rvalid_i && !pc_empty;
  assign rsp_drop = rsp_fire && (redirect_i || (discard_cnt != '0));
  assign rsp_keep = rsp_fire && !rsp_drop;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      discard_cnt <= discard_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    discard_next = discard_cnt;
    if (redirect_i) begin
      // Everything still in flight after this edge is stale, including a
      // grant taken this cycle; a response this cycle is already dropped.
      discard_next = outstanding + OCNT_W'(gnt_fire) - OCNT_W'(rsp_fire);
    end else if (rsp_drop) begin
      discard_next = discard_cnt - 1'b1;
    end
  end

  always_comb begin
    pc_next = pc;
    if (redirect_i)    pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
    else if (gnt_fire) pc_next = pc + XLEN'(FETCH_PC_STEP);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (discard_next != '0) state_next = ST_DRAIN;
      ST_DRAIN: if (discard_next == '0) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    imem_req_o = 1'b0;
    if (state == ST_RUN) begin
      imem_req_o = (int'(outstanding) < MAX_OUTSTANDING) &&
                   ((int'(q_count) + int'(outstanding)) < DEPTH);
    end
  end

  // The address is the fetch PC, which only moves on a grant or redirect,
  // so it holds while a request waits for its grant.
  assign imem_addr_o = pc;

  // ---------------- decode side ----------------
  always_comb begin
    fetch_valid_o              = !q_empty;
    {fetch_pc_o, fetch_inst_o} = q_rdata;
    q_push                     = rsp_keep;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (q_empty && rsp_keep) begin
      fetch_valid_o = 1'b1;
      fetch_pc_o    = rsp_pc;
      fetch_inst_o  = imem_rdata_i;
      q_push        = !fetch_ready_i;
    end
`endif
  end

  assign q_pop     = !q_empty && fetch_ready_i;
  assign q_count_o = q_count;

  // Request PCs in issue order; stale responses still pop their PC, so
  // the FIFO count doubles as the outstanding-request count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (gnt_fire),
    .wdata (pc),
    .pop   (rsp_fire),
    .rdata (rsp_pc),
    .empty (pc_empty),
    .count (outstanding)
  );

  // Entry queue of {pc, inst}; a redirect flushes it even when decode
  // takes the head in the same cycle.
  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_i),
    .push  (q_push),
    .wdata ({rsp_pc, imem_rdata_i}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (XLEN=32, DEPTH=4, MAX_OUTSTANDING=2,
// RESET_PC=0). Inputs change 1 time unit after the rising edge and outputs
// are sampled 1 time unit later. The instruction memory is scripted cycle by
// cycle; instruction words are derived from their address by inst_of().
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_inst_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [2:0]  q_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_queue #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_inst_o  (fetch_inst_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .q_count_o     (q_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
    imem_gnt_i    = gnt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    fetch_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  int          grants;
  logic        prev_gnt;
  logic [31:0] last_addr;
  logic [31:0] first_addr;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    check("rst_req", imem_req_o, 1);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", fetch_valid_o, 0);
    check("rst_qcount", q_count_o, 0);

    // ---------------- sequential fetch, ready=1 ----------------
    next_cycle();
    drive(1, 1, inst_of(32'h0), 1, 0, 0);
    check("seq_addr1", imem_addr_o, 32'h4);
    next_cycle();
    drive(1, 1, inst_of(32'h4), 1, 0, 0);
    check("seq_addr2", imem_addr_o, 32'h8);
    check("seq_valid0", fetch_valid_o, 1);
    check("seq_pc0", fetch_pc_o, 32'h0);
    check("seq_inst0", fetch_inst_o, 32'h1300_0000);
    next_cycle();
    drive(0, 1, inst_of(32'h8), 1, 0, 0);
    check("seq_pc1", fetch_pc_o, 32'h4);
    check("seq_inst1", fetch_inst_o, 32'h1300_0004);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("seq_pc2", fetch_pc_o, 32'h8);
    check("seq_inst2", fetch_inst_o, 32'h1300_0008);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("seq_empty", fetch_valid_o, 0);
    check("seq_hold_addr", imem_addr_o, 32'hC);

    // ---------------- back-pressure, ready=0 ----------------
    next_cycle();
    grants    = 0;
    prev_gnt  = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, prev_gnt, inst_of(last_addr), 0, 0, 0);
      if (imem_req_o) grants++;
      prev_gnt  = imem_req_o;
      last_addr = imem_addr_o;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    check("bp_grants", grants, 4);
    check("bp_req_low", imem_req_o, 0);
    check("bp_qcount", q_count_o, 4);
    check("bp_head_pc", fetch_pc_o, 32'hC);
    check("bp_head_inst", fetch_inst_o, 32'h1300_000C);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("bp_stable_pc", fetch_pc_o, 32'hC);
    next_cycle();
    grants     = 0;
    prev_gnt   = 1'b0;
    first_addr = '1;
    for (int i = 0; i < 4; i++) begin
      drive(1, prev_gnt, inst_of(last_addr), 0, 0, 0);
      if (imem_req_o) begin
        grants++;
        first_addr = imem_addr_o;
      end
      prev_gnt  = imem_req_o;
      last_addr = imem_addr_o;
      next_cycle();
    end
    check("bp_one_more", grants, 1);
    check("bp_new_addr", first_addr, 32'h1C);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      check($sformatf("bp_drain_pc%0d", i), fetch_pc_o, 32'h10 + 32'(4 * i));
      next_cycle();
    end
    drive(0, 0, 0, 1, 0, 0);
    check("bp_drained", q_count_o, 0);

    // ---------------- redirect with two outstanding ----------------
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check("rd_addr_a", imem_addr_o, 32'h20);
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check("rd_addr_b", imem_addr_o, 32'h24);
    next_cycle();
    drive(0, 0, 0, 1, 1, 32'h103);
    check("rd_credit_full", imem_req_o, 0);
    next_cycle();
    drive(0, 1, 32'hDEAD_0020, 1, 0, 0);
    check("rd_drain_req1", imem_req_o, 0);
    check("rd_drain_valid1", fetch_valid_o, 0);
    next_cycle();
    drive(0, 1, 32'hDEAD_0024, 1, 0, 0);
    check("rd_drain_req2", imem_req_o, 0);
    check("rd_drain_valid2", fetch_valid_o, 0);
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check("rd_run_req", imem_req_o, 1);
    check("rd_target", imem_addr_o, 32'h100);
    check("rd_no_stale", fetch_valid_o, 0);
    check("rd_no_stale_q", q_count_o, 0);
    next_cycle();
    drive(0, 1, inst_of(32'h100), 1, 0, 0);
    check("rd_lat_valid", fetch_valid_o, 0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("rd_tgt_valid", fetch_valid_o, 1);
    check("rd_tgt_pc", fetch_pc_o, 32'h100);
    check("rd_tgt_inst", fetch_inst_o, 32'h1300_0100);

    // ---------------- redirect + rvalid + dequeue together ----------------
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check("rdq_addr", imem_addr_o, 32'h104);
    next_cycle();
    drive(1, 1, inst_of(32'h104), 1, 0, 0);
    next_cycle();
    drive(0, 1, inst_of(32'h108), 1, 1, 32'h200);
    check("rdq_head_valid", fetch_valid_o, 1);
    check("rdq_head_pc", fetch_pc_o, 32'h104);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("rdq_qcount", q_count_o, 0);
    check("rdq_valid", fetch_valid_o, 0);
    check("rdq_req", imem_req_o, 1);
    check("rdq_addr_tgt", imem_addr_o, 32'h200);

    // ---------------- reset during DRAIN ----------------
    next_cycle();
    drive(1, 0, 0, 1, 0, 0);
    check("rsd_addr", imem_addr_o, 32'h200);
    next_cycle();
    drive(0, 0, 0, 1, 1, 32'h300);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("rsd_in_drain", imem_req_o, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 1, 32'hBAD0_0BAD, 1, 0, 0);
    check("rsd_req", imem_req_o, 1);
    check("rsd_addr_rst", imem_addr_o, 32'h0);
    check("rsd_valid", fetch_valid_o, 0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("rsd_late_q", q_count_o, 0);
    check("rsd_late_valid", fetch_valid_o, 0);
    check("rsd_addr_hold", imem_addr_o, 32'h0);

    // ---------------- response latency / bypass ----------------
    next_cycle();
    drive(1, 0, 0, 0, 0, 0);
    check("lat_addr", imem_addr_o, 32'h0);
    next_cycle();
    drive(0, 1, 32'h00A0_0093, 0, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_valid", fetch_valid_o, 1);
    check("byp_inst", fetch_inst_o, 32'h00A0_0093);
    check("byp_pc", fetch_pc_o, 32'h0);
`else
    check("lat_not_yet", fetch_valid_o, 0);
`endif
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    check("lat_valid", fetch_valid_o, 1);
    check("lat_inst", fetch_inst_o, 32'h00A0_0093);
    check("lat_qcount", q_count_o, 1);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("lat_drained", q_count_o, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    drive(1, 0, 0, 1, 0, 0);
    next_cycle();
    drive(0, 1, 32'h0010_0113, 1, 0, 0);
    check("byp2_valid", fetch_valid_o, 1);
    check("byp2_pc", fetch_pc_o, 32'h4);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    check("byp2_skip_q", q_count_o, 0);
    check("byp2_gone", fetch_valid_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
